// File: rtl/cmp_rr_arbiter_if.sv
// Request/grant and result handshake bundle for the shared comparator.
// master: client side (drives requests, operands, res_ready).
// slave:  arbiter side (drives grants and the buffered result).
interface cmp_rr_arbiter_if #(
  parameter int N  = 8,
  parameter int R  = 4,
  parameter int RW = 2
);
  logic [R-1:0]   req;
  logic [R*N-1:0] a_flat;
  logic [R*N-1:0] b_flat;
  logic [R-1:0]   gnt;
  logic           res_valid;
  logic           res_ready;
  logic [RW-1:0]  res_id;
  logic           res_eq;
  logic           res_gt;
  logic           res_lt;

  modport master (
    output req, a_flat, b_flat, res_ready,
    input  gnt, res_valid, res_id, res_eq, res_gt, res_lt
  );

  modport slave (
    input  req, a_flat, b_flat, res_ready,
    output gnt, res_valid, res_id, res_eq, res_gt, res_lt
  );
endinterface

// File: rtl/cmp_rr_arbiter.sv
// Round-robin front end for one shared N-bit unsigned comparator.
// A granted pair is compared and stored in a single-entry result buffer
// that drains over valid/ready; a pop and a new grant may share an edge.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_EMPTY | no result buffered, any request may be granted
//   S_FULL  | result held; grant only if it is popped this edge
module cmp_rr_arbiter #(
  parameter int N  = 8,
  parameter int R  = 4,
  parameter int RW = 2
) (
  input  logic              clk,
  input  logic              rst,
  cmp_rr_arbiter_if.slave   io_bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_ptr;
  logic [RW-1:0] r_res_id;
  logic          r_res_eq;
  logic          r_res_gt;
  logic          r_res_lt;

  logic          w_can_accept;
  logic          w_grant;
  logic [R-1:0]  w_gnt;
  logic [RW-1:0] w_gnt_id;
  logic [RW-1:0] w_ptr_nxt;
  logic [RW-1:0] w_sel;
  int            w_idx;
  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;

  // A slot is free when empty, or when the held result leaves this edge.
  assign w_can_accept = (r_state == S_EMPTY) || io_bus.res_ready;

  // Buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Buffer next state: a grant always fills, a pop without a grant empties.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_grant) begin
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (io_bus.res_ready && !w_grant) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Round-robin scan starting at r_ptr; index wraps at R, not 2**RW.
  always_comb begin
    w_gnt    = '0;
    w_gnt_id = '0;
    w_grant  = 1'b0;
    w_idx    = 0;
    w_sel    = '0;
    if (w_can_accept) begin
      for (int i = 0; i < R; i++) begin
        w_idx = int'(r_ptr) + i;
        if (w_idx >= R) begin
          w_idx = w_idx - R;
        end
        w_sel = RW'(w_idx);
        if (!w_grant && io_bus.req[w_sel]) begin
          w_grant        = 1'b1;
          w_gnt_id       = w_sel;
          w_gnt[w_sel]   = 1'b1;
        end
      end
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < R; k++) begin
      if (w_gnt_id == RW'(k)) begin
        w_a = io_bus.a_flat[k*N +: N];
        w_b = io_bus.b_flat[k*N +: N];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == RW'(R-1)) ? '0 : w_gnt_id + 1'b1;

  // Result and pointer registers: update only on a grant, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_res_id <= '0;
      r_res_eq <= 1'b0;
      r_res_gt <= 1'b0;
      r_res_lt <= 1'b0;
    end else if (w_grant) begin
      r_ptr    <= w_ptr_nxt;
      r_res_id <= w_gnt_id;
      r_res_eq <= (w_a == w_b);
      r_res_gt <= (w_a > w_b);
      r_res_lt <= (w_a < w_b);
    end
  end

  assign io_bus.gnt       = w_gnt;
  assign io_bus.res_valid = (r_state == S_FULL);
  assign io_bus.res_id    = r_res_id;
  assign io_bus.res_eq    = r_res_eq;
  assign io_bus.res_gt    = r_res_gt;
  assign io_bus.res_lt    = r_res_lt;

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Bench for cmp_rr_arbiter: an R=4 and an R=3 instance share clock and reset.
// Vectors hold hand-derived grants; results are predicted at grant time into
// a queue and compared while the DUT holds them.
module tb_cmp_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_rr_arbiter_if #(.N(8), .R(4), .RW(2)) bus4 ();
  cmp_rr_arbiter_if #(.N(8), .R(3), .RW(2)) bus3 ();

  cmp_rr_arbiter #(.N(8), .R(4), .RW(2)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus4.slave)
  );

  cmp_rr_arbiter #(.N(8), .R(3), .RW(2)) dut3 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus3.slave)
  );

  typedef struct {
    bit          sel3;
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [3:0]  gnt;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic       eq;
    logic       gt;
    logic       lt;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input bit s, input logic [3:0] rq, input logic [31:0] a,
                     input logic [31:0] b, input logic r, input logic [3:0] g);
    vec_t v;
    v.sel3 = s; v.req = rq; v.a = a; v.b = b; v.rdy = r; v.gnt = g;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic [3:0] g;
    logic       val;
    res_t       cur;
    res_t       e;
    int         kk;
    logic [7:0] ea;
    logic [7:0] eb;
    @(negedge clk);
    if (v.sel3) begin
      bus3.req = v.req[2:0]; bus3.a_flat = v.a[23:0]; bus3.b_flat = v.b[23:0];
      bus3.res_ready = v.rdy;
      bus4.req = '0; bus4.res_ready = 1'b1;
    end else begin
      bus4.req = v.req; bus4.a_flat = v.a; bus4.b_flat = v.b;
      bus4.res_ready = v.rdy;
      bus3.req = '0; bus3.res_ready = 1'b1;
    end
    #1;
    if (v.sel3) begin
      g = {1'b0, bus3.gnt}; val = bus3.res_valid;
      cur = {bus3.res_id, bus3.res_eq, bus3.res_gt, bus3.res_lt};
    end else begin
      g = bus4.gnt; val = bus4.res_valid;
      cur = {bus4.res_id, bus4.res_eq, bus4.res_gt, bus4.res_lt};
    end
    chk("gnt", 32'(g), 32'(v.gnt));
    chk("res_valid", 32'(val), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("result{id,eq,gt,lt}", 32'(cur), 32'(sb[0]));
      if (v.rdy) void'(sb.pop_front());
    end
    if (v.gnt != 4'd0) begin
      kk = 0;
      for (int k = 0; k < 4; k++) if (v.gnt[k]) kk = k;
      ea = v.a[kk*8 +: 8];
      eb = v.b[kk*8 +: 8];
      e.id = 2'(kk); e.eq = (ea == eb); e.gt = (ea > eb); e.lt = (ea < eb);
      sb.push_back(e);
    end
  endtask

  initial begin
    // R=4 operands: 0:FF/FF eq, 1:00/FF lt, 2:80/7F gt, 3:FF/00 gt
    logic [31:0] a4, b4, a3, b3;
    a4 = 32'hFF80_00FF; b4 = 32'h007F_FFFF;
    // R=3 operands: 0:30/20 gt, 1:20/30 lt, 2:10/10 eq
    a3 = 32'h0010_2030; b3 = 32'h0010_3020;

    add(0, 4'b0001, 32'h0000_007F, 32'h0000_0080, 1, 4'b0001);
    add(0, 4'b0000, a4, b4, 1, 4'b0000);
    add(0, 4'b1111, a4, b4, 1, 4'b0010);
    add(0, 4'b1111, a4, b4, 1, 4'b0100);
    add(0, 4'b1111, a4, b4, 1, 4'b1000);
    add(0, 4'b1111, a4, b4, 1, 4'b0001);
    add(0, 4'b1111, a4, b4, 1, 4'b0010);
    add(0, 4'b1111, a4, b4, 1, 4'b0100);
    add(0, 4'b0000, a4, b4, 1, 4'b0000);
    add(0, 4'b0001, a4, b4, 1, 4'b0001);
    for (int i = 0; i < 5; i++) add(0, 4'b1111, a4, b4, 0, 4'b0000);
    add(0, 4'b1111, a4, b4, 1, 4'b0010);
    add(0, 4'b0000, a4, b4, 1, 4'b0000);
    add(0, 4'b1000, a4, b4, 1, 4'b1000);
    add(0, 4'b0100, a4, b4, 0, 4'b0000);
    add(0, 4'b0000, a4, b4, 1, 4'b0000);
    add(0, 4'b0011, a4, b4, 1, 4'b0001);
    add(0, 4'b0011, a4, b4, 1, 4'b0010);
    add(0, 4'b0011, a4, b4, 1, 4'b0001);
    add(0, 4'b0000, a4, b4, 1, 4'b0000);
    add(1, 4'b0010, a3, b3, 1, 4'b0010);
    add(1, 4'b0000, a3, b3, 1, 4'b0000);
    add(1, 4'b0011, a3, b3, 1, 4'b0001);
    add(1, 4'b0100, a3, b3, 1, 4'b0100);
    add(1, 4'b0111, a3, b3, 1, 4'b0001);
    add(1, 4'b0000, a3, b3, 1, 4'b0000);

    rst = 1'b1;
    bus4.req = '0; bus4.a_flat = '0; bus4.b_flat = '0; bus4.res_ready = 1'b1;
    bus3.req = '0; bus3.a_flat = '0; bus3.b_flat = '0; bus3.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle gnt", 32'(bus4.gnt), 32'd0);
      chk("idle res_valid", 32'(bus4.res_valid), 32'd0);
      chk("idle {id,eq,gt,lt}",
          32'({bus4.res_id, bus4.res_eq, bus4.res_gt, bus4.res_lt}), 32'd0);
    end

    foreach (vecs[i]) apply(vecs[i]);

    // Reset in the middle of a stall: FULL with ptr=3, then async reset.
    begin
      vec_t v;
      v.sel3 = 0; v.a = a4; v.b = b4;
      v.req = 4'b0100; v.rdy = 1; v.gnt = 4'b0100; apply(v);
      v.req = 4'b1111; v.rdy = 0; v.gnt = 4'b0000; apply(v);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst res_valid", 32'(bus4.res_valid), 32'd0);
      chk("rst {id,eq,gt,lt}",
          32'({bus4.res_id, bus4.res_eq, bus4.res_gt, bus4.res_lt}), 32'd0);
      sb.delete();
      #1 rst = 1'b0;
      v.req = 4'b1111; v.rdy = 1; v.gnt = 4'b0001; apply(v);
      v.req = 4'b0000; v.rdy = 1; v.gnt = 4'b0000; apply(v);
      v.req = 4'b0000; v.rdy = 1; v.gnt = 4'b0000; apply(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
